coeff_sum_tree: RTL

COEFF_SUM_TREE -- requirements
Module: coeff_sum_tree

---
 rtl/coeff_sum_tree.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/coeff_sum_tree.sv
// Masked coefficient sum: a 3:2 carry-save tree with a final carry-propagate add,
// a valid/last shadow pipeline that stalls as one, and a per-frame running accumulator.
module coeff_sum_tree #(
    parameter int BITS    = 32,
    parameter int CGES    = 13,
    parameter int MAX     = $clog2(CGES) + BITS,
    parameter int ACC_EXT = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      coef_we,
    input  logic [$clog2(CGES)-1:0]   coef_addr,
    input  logic [BITS-1:0]           coef_wdata,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CGES-1:1]           cges,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAX-1:0]            sum,
    output logic [MAX+ACC_EXT-1:0]    acc,
    output logic                      out_last
);

    localparam int ACCW = MAX + ACC_EXT;

    // Operand count after one 3:2 level: each full triple becomes sum+carry, leftovers pass.
    function automatic int reduce_ops(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    function automatic int ops_after(input int n, input int lvls);
        int cnt;
        cnt = n;
        for (int i = 0; i < lvls; i++) begin
            cnt = reduce_ops(cnt);
        end
        return cnt;
    endfunction

    function automatic int count_levels(input int n);
        int cnt;
        int lvl;
        cnt = n;
        lvl = 0;
        for (int i = 0; i < 16; i++) begin
            if (cnt > 2) begin
                cnt = reduce_ops(cnt);
                lvl++;
            end
        end
        return lvl;
    endfunction

    localparam int NLEV = count_levels(CGES);

    logic [BITS-1:0]  coef_q [CGES];
    logic [CGES-1:0]  en;
    logic             stall;
    logic             adv;
    logic [NLEV+1:0]  vld_q;
    logic [NLEV+1:0]  lst_q;
    logic [MAX-1:0]   sum_q;
    logic [ACCW-1:0]  acc_prev_q;
    logic [ACCW-1:0]  acc_d;

    assign en       = {cges, 1'b1};
    assign stall    = vld_q[NLEV+1] & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < CGES; k++) begin
                coef_q[k] <= '0;
            end
        end else if (coef_we && (32'(coef_addr) < CGES)) begin
            coef_q[coef_addr] <= coef_wdata;
        end
    end

    // Level 0 registers the masked terms at the acceptance edge, so a coefficient
    // write on that same edge only reaches later samples.
    for (genvar gi = 0; gi <= NLEV; gi++) begin : g_lvl
        logic [MAX-1:0] stage_d [CGES];
        logic [MAX-1:0] stage_q [CGES];

        if (gi == 0) begin : g_terms
            always_comb begin
                for (int k = 0; k < CGES; k++) begin
                    stage_d[k] = en[k] ? MAX'($signed(coef_q[k])) : '0;
                end
            end
        end else begin : g_csa
            localparam int NIN  = ops_after(CGES, gi - 1);
            localparam int NGRP = NIN / 3;

            always_comb begin
                logic [MAX-1:0] a;
                logic [MAX-1:0] b;
                logic [MAX-1:0] c;
                logic [MAX-1:0] maj;
                for (int k = 0; k < CGES; k++) begin
                    stage_d[k] = '0;
                end
                for (int g = 0; g < NGRP; g++) begin
                    a   = g_lvl[gi-1].stage_q[3*g];
                    b   = g_lvl[gi-1].stage_q[3*g+1];
                    c   = g_lvl[gi-1].stage_q[3*g+2];
                    maj = (a & b) | (a & c) | (b & c);
                    stage_d[2*g]   = a ^ b ^ c;
                    stage_d[2*g+1] = {maj[MAX-2:0], 1'b0};
                end
                for (int r = 0; r < NIN % 3; r++) begin
                    stage_d[2*NGRP+r] = g_lvl[gi-1].stage_q[3*NGRP+r];
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k < CGES; k++) begin
                    stage_q[k] <= '0;
                end
            end else if (adv) begin
                for (int k = 0; k < CGES; k++) begin
                    stage_q[k] <= stage_d[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
            vld_q <= '0;
            lst_q <= '0;
        end else if (adv) begin
            sum_q <= g_lvl[NLEV].stage_q[0] + g_lvl[NLEV].stage_q[1];
            vld_q <= {vld_q[NLEV:0], in_valid};
            lst_q <= {lst_q[NLEV:0], in_valid & in_last};
        end
    end

    assign acc_d = acc_prev_q + ACCW'($signed(sum_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_prev_q <= '0;
        end else if (vld_q[NLEV+1] && out_ready) begin
            acc_prev_q <= lst_q[NLEV+1] ? '0 : acc_d;
        end
    end

    assign out_valid = vld_q[NLEV+1];
    assign out_last  = lst_q[NLEV+1];
    assign sum       = sum_q;
    assign acc       = acc_d;

endmodule
